// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux_reg registered arbiter/mux.
//   MODE_SEL / MODE_RR : values of the top-level mode input
//   MAX_N              : largest supported channel count
//   onehot(idx, n)     : one-hot vector with bit idx set, zero when idx >= n
package arb_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
  localparam int   MAX_N    = 16;

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (idx < n && idx < MAX_N) v = MAX_N'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/arb_mux_reg_rr_pick.sv
// rr_pick: combinational rotating priority encoder.
//   valid       in  N     per-channel request
//   ptr         in  SELW  highest-priority channel this cycle
//   grant       out SELW  first valid channel at ptr, ptr+1, ... mod N
//   grant_valid out 1     some channel is valid
module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    // Walk from lowest to highest priority so the closest valid channel to ptr wins last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (valid[idx]) begin
        grant       = SELW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_reg.sv
// arb_mux_reg: N-input WIDTH-bit registered mux with valid/ready flow control.
// Source chosen by external select (mode=0) or round-robin arbitration (mode=1).
// One output register, 1-cycle latency, full throughput when out_ready stays high.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   mode, sel             arbitration mode, channel index for mode=0
//   in_data/in_valid      N packed channels and their valids
//   in_ready              per-channel accept strobe (at most one set)
//   in_last               (ARB_MUX_LOCK_EN only) end-of-packet marker per channel
//   out_data/out_src      registered beat and the channel it came from
//   out_valid/out_ready   output handshake
// Build option: define ARB_MUX_LOCK_EN to keep a channel granted until its in_last beat.
module arb_mux_reg
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]      in_valid,
`ifdef ARB_MUX_LOCK_EN
  input  logic [N-1:0]      in_last,
`endif
  output logic [N-1:0]      in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [SELW-1:0]   out_src,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  rr_grant;
  logic             rr_valid;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             load;
  logic [MAX_N-1:0] grant_oh;
`ifdef ARB_MUX_LOCK_EN
  logic             lock;
`endif

  rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
    .valid       (in_valid),
    .ptr         (ptr),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
`ifdef ARB_MUX_LOCK_EN
    if (lock) begin
      grant       = out_src;
      grant_valid = in_valid[out_src];
    end else
`endif
    if (mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else if (32'(sel) < N) begin
      grant       = sel;
      grant_valid = in_valid[sel];
    end
  end

  // rst_n gating keeps in_ready low while reset is asserted.
  assign load     = grant_valid && (!out_valid || out_ready) && rst_n;
  assign grant_oh = onehot(32'(grant), N);
  assign in_ready = grant_oh[N-1:0] & {N{load}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data[32'(grant)*WIDTH +: WIDTH];
      out_src   <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  logic ptr_upd;
`ifdef ARB_MUX_LOCK_EN
  // Pointer advances only when a packet ends, so a locked packet counts as one turn.
  assign ptr_upd = load && (mode == MODE_RR) && in_last[grant];
`else
  assign ptr_upd = load && (mode == MODE_RR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (ptr_upd) begin
      if (32'(grant) == N - 1) ptr <= '0;
      else                     ptr <= grant + 1'b1;
    end
  end

`ifdef ARB_MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lock <= 1'b0;
    else if (load) lock <= !in_last[grant];
  end
`endif

endmodule

// File: tb/tb_arb_mux_reg.sv
module tb_arb_mux_reg;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [WIDTH-1:0]  out_data;
  logic [SELW-1:0]   out_src;
  logic              out_valid;
  logic              out_ready;
`ifdef ARB_MUX_LOCK_EN
  logic [N-1:0]      in_last;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] chd [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};

  always #5 clk = ~clk;

  arb_mux_reg #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef ARB_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic test_reset();
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    in_data   = {chd[3], chd[2], chd[1], chd[0]};
    out_ready = 1'b0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", out_data); end
    n_checks++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_src got=%0d exp=0", out_src); end
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      n_fail++; $display("FAIL first_load got=%b/%h exp=1/11", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
      n_fail++; $display("FAIL async_reset got=%b/%h/%0d exp=0/00/0", out_valid, out_data, out_src);
    end
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready2 got=%b exp=0000", in_ready); end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 4'b0000;
  endtask

  task automatic test_sel();
    @(negedge clk);
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL sel_in_ready got=%b exp=0100", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2) begin
      n_fail++; $display("FAIL sel_out got=%b/%h/%0d exp=1/a5/2", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_sel_invalid();
    @(negedge clk);
    sel = 2'd1; in_valid = 4'b1101;
    #1;
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL selinv_in_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL selinv_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_rr_all();
    logic [3:0] exp_rdy;
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_first_ready got=%b exp=0001", in_ready); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_src !== 2'(i % 4) || out_data !== chd[i % 4] || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL rr_all[%0d] got=%0d/%h exp=%0d/%h", i, out_src, out_data, i % 4, chd[i % 4]);
      end
      exp_rdy = 4'b0001 << ((i + 1) % 4);
      n_checks++; if (in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rr_all_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy);
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [1:0] exp_src [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    @(negedge clk);
    in_valid = 4'b1010;
    #1;
    n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL sparse_ready got=%b exp=0010", in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_src !== exp_src[i] || out_data !== chd[exp_src[i]]) begin
        n_fail++; $display("FAIL sparse[%0d] got=%0d/%h exp=%0d/%h", i, out_src, out_data, exp_src[i], chd[exp_src[i]]);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready got=%b exp=0000", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h44 || out_src !== 2'd3 || in_ready !== 4'b0000) begin
        n_fail++; $display("FAIL stall[%0d] got=%b/%h/%0d/%b exp=1/44/3/0000", i, out_valid, out_data, out_src, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL unstall_ready got=%b exp=0010", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_src !== 2'd1 || out_data !== 8'h22) begin
      n_fail++; $display("FAIL unstall_out got=%0d/%h exp=1/22", out_src, out_data);
    end
  endtask

  task automatic test_drain();
    @(negedge clk);
    in_valid = 4'b0000;
    #1;
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL drain_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h22) begin
      n_fail++; $display("FAIL drain got=%b/%h exp=0/22", out_valid, out_data);
    end
  endtask

  task automatic test_mode_switch();
    @(negedge clk);
    mode = 1'b0; sel = 2'd3; in_valid = 4'b1111;
    #1;
    n_checks++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL switch_sel got=%b exp=1000", in_ready); end
    mode = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL switch_rr got=%b exp=0100", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_src !== 2'd2 || out_data !== 8'hA5) begin
      n_fail++; $display("FAIL switch_out got=%0d/%h exp=2/a5", out_src, out_data);
    end
  endtask

`ifdef ARB_MUX_LOCK_EN
  task automatic test_lock();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n     = 1'b1;
    mode      = 1'b1;
    in_valid  = 4'b0011;
    in_last   = 4'b0010;
    out_ready = 1'b1;
    in_data   = {8'h00, 8'h00, 8'hB1, 8'hA0};
    for (int b = 0; b < 3; b++) begin
      if (b > 0) begin
        @(negedge clk);
        in_data[7:0] = 8'hA0 + 8'(b);
        in_last[0]   = (b == 2);
      end
      @(posedge clk); #1;
      n_checks++; if (out_src !== 2'd0 || out_data !== 8'hA0 + 8'(b)) begin
        n_fail++; $display("FAIL lock_beat[%0d] got=%0d/%h exp=0/%h", b, out_src, out_data, 8'hA0 + 8'(b));
      end
    end
    @(posedge clk); #1;
    n_checks++; if (out_src !== 2'd1 || out_data !== 8'hB1) begin
      n_fail++; $display("FAIL lock_release got=%0d/%h exp=1/b1", out_src, out_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sel();
    test_sel_invalid();
    test_rr_all();
    test_rr_sparse();
    test_drain();
    test_mode_switch();
`ifdef ARB_MUX_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
